// File: rtl/joypad_serial_reader.sv
// Serial joypad reader for 4021-style shift-register controllers.
// It strobes pad_latch, then clocks out eight active-low button bits. The
// bits are published on buttons together with a one-cycle valid pulse.
// A poll starts on request or when the optional auto-poll timer expires.
module joypad_serial_reader #(
   parameter int LATCH_CYCLES = 300,
   parameter int HALF_CYCLES  = 150,
   parameter int POLL_CYCLES  = 416667
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       auto_en,
   input  logic       poll_req,
   input  logic       pad_data,
   output logic       pad_latch,
   output logic       pad_clk,
   output logic [7:0] buttons,
   output logic       valid,
   output logic       busy
);

   // The phase counter is shared by LATCH, LOW and HIGH, so it is sized for the longest phase.
   localparam int PHASE_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
   localparam int CNT_W     = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
   localparam int POLL_W    = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_LOW,
      ST_HIGH,
      ST_DONE
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        n_q;
   logic [7:0]        bits_q;
   logic [7:0]        capt_bits;
   logic [7:0]        buttons_q;
   logic              valid_q;
   logic              pad_latch_q;
   logic              pad_clk_q;
   logic              pending_q;
   logic              pending_d;
   logic [POLL_W-1:0] timer_q;
   logic [POLL_W-1:0] timer_d;
   logic              expiry;
   logic              sync1_q;
   logic              sync2_q;

   // Two-flop synchronizer for the asynchronous pad data (idles high = released)
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= pad_data;
         sync2_q <= sync1_q;
      end
   end

   // Poll timer next state: free-runs while auto-poll is enabled and parks at zero otherwise
   always_comb begin
      expiry  = auto_en && (timer_q == POLL_W'(POLL_CYCLES - 1));
      timer_d = timer_q + POLL_W'(1);
      if (!auto_en || expiry) begin
         timer_d = '0;
      end
   end

   // Poll timer register
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   // Pending flag merges requests and expiries; IDLE consumes it when a transaction starts
   always_comb begin
      if (state_q == ST_IDLE && pending_q) begin
         pending_d = poll_req | expiry;
      end else begin
         pending_d = pending_q | poll_req | expiry;
      end
   end

   // Captured vector with the current bit replaced by the inverted pad sample
   always_comb begin
      capt_bits      = bits_q;
      capt_bits[n_q] = ~sync2_q;
   end

   // Transaction FSM; pad strobes, buttons and valid are registered with the state
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         n_q         <= '0;
         bits_q      <= '0;
         buttons_q   <= '0;
         valid_q     <= 1'b0;
         pad_latch_q <= 1'b0;
         pad_clk_q   <= 1'b0;
         pending_q   <= 1'b0;
      end else begin
         pending_q <= pending_d;
         valid_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pending_q) begin
                  state_q     <= ST_LATCH;
                  pad_latch_q <= 1'b1;
                  cnt_q       <= '0;
               end
            end
            ST_LATCH: begin
               if (cnt_q == CNT_W'(LATCH_CYCLES - 1)) begin
                  state_q     <= ST_LOW;
                  pad_latch_q <= 1'b0;
                  cnt_q       <= '0;
                  n_q         <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_LOW: begin
               if (cnt_q == CNT_W'(HALF_CYCLES - 1)) begin
                  bits_q <= capt_bits;
                  cnt_q  <= '0;
                  if (n_q == 3'd7) begin
                     // Last bit: publish the whole byte at once while DONE is shown
                     state_q   <= ST_DONE;
                     buttons_q <= capt_bits;
                     valid_q   <= 1'b1;
                  end else begin
                     state_q   <= ST_HIGH;
                     pad_clk_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_HIGH: begin
               if (cnt_q == CNT_W'(HALF_CYCLES - 1)) begin
                  state_q   <= ST_LOW;
                  pad_clk_q <= 1'b0;
                  cnt_q     <= '0;
                  n_q       <= n_q + 3'd1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q     <= ST_IDLE;
               pad_latch_q <= 1'b0;
               pad_clk_q   <= 1'b0;
            end
         endcase
      end
   end

   assign pad_latch = pad_latch_q;
   assign pad_clk   = pad_clk_q;
   assign buttons   = buttons_q;
   assign valid     = valid_q;
   assign busy      = (state_q != ST_IDLE);

endmodule
